neuron_mac_ctrl: RTL and testbench

NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

---
 rtl/neuron_mac_ctrl.sv | 122 ++++++++++++
 tb/tb_neuron_mac_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_ctrl.sv
// Dot-product sequencer for a neuron: streams shared input/weight addresses,
// accumulates multiplier products onto a bias and reports the sum with a done pulse.
module neuron_mac_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vec_len,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  mul_valid,
    input  logic [DATA_WIDTH-1:0] mul_result,
    input  logic                  mul_result_valid,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ZERO_CNT = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_r;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   issue_cnt_r;
    logic [ADDR_WIDTH:0]   accept_cnt_r;
    logic [DATA_WIDTH-1:0] acc_r;

    logic [ADDR_WIDTH:0]   len_clamped_s;
    logic [ADDR_WIDTH:0]   accept_next_s;
    logic [DATA_WIDTH-1:0] acc_next_s;

    // Clamped job length and next-value helpers for the accumulate path
    always_comb begin
        len_clamped_s = (vec_len > MAX_LEN) ? MAX_LEN : vec_len;
        accept_next_s = accept_cnt_r + ONE_CNT;
        acc_next_s    = acc_r + mul_result;
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            len_r        <= ZERO_CNT;
            issue_cnt_r  <= ZERO_CNT;
            accept_cnt_r <= ZERO_CNT;
            acc_r        <= {DATA_WIDTH{1'b0}};
            rd_en        <= 1'b0;
            rd_addr      <= {ADDR_WIDTH{1'b0}};
            mul_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sum          <= {DATA_WIDTH{1'b0}};
        end else begin
            mul_valid <= rd_en;
            done      <= 1'b0;
            // Products are only meaningful inside a job; stray ones in IDLE are dropped
            if ((state_r != IDLE) && mul_result_valid) begin
                acc_r        <= acc_next_s;
                accept_cnt_r <= accept_next_s;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r        <= len_clamped_s;
                        acc_r        <= bias;
                        accept_cnt_r <= ZERO_CNT;
                        busy         <= 1'b1;
                        if (vec_len == ZERO_CNT) begin
                            state_r     <= DONE;
                            issue_cnt_r <= ZERO_CNT;
                            done        <= 1'b1;
                            sum         <= bias;
                        end else begin
                            state_r     <= ISSUE;
                            issue_cnt_r <= ONE_CNT;
                            rd_en       <= 1'b1;
                            rd_addr     <= {ADDR_WIDTH{1'b0}};
                        end
                    end
                end
                ISSUE: begin
                    if (issue_cnt_r == len_r) begin
                        rd_en   <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        rd_addr     <= issue_cnt_r[ADDR_WIDTH-1:0];
                        issue_cnt_r <= issue_cnt_r + ONE_CNT;
                    end
                end
                DRAIN: begin
                    // The last product arrives here: finish on the cycle it is accepted
                    if (mul_result_valid && (accept_next_s == len_r)) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        sum     <= acc_next_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rd_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Randomized self-checking bench for neuron_mac_ctrl with memory/multiplier
// models and a dot-product reference computed directly from the stored vectors.
module tb_neuron_mac_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] vec_len;
    logic [31:0] bias;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        mul_valid;
    logic [31:0] mul_result;
    logic        mul_result_valid;
    logic        busy;
    logic        done;
    logic [31:0] sum;

    logic [31:0] in_mem [0:1023];
    logic [31:0] wt_mem [0:1023];
    logic [31:0] mem_in_q;
    logic [31:0] mem_wt_q;
    logic [31:0] last_sum;

    int n_checks;
    int n_errors;

    neuron_mac_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .vec_len(vec_len),
        .bias(bias),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .mul_valid(mul_valid),
        .mul_result(mul_result),
        .mul_result_valid(mul_result_valid),
        .busy(busy),
        .done(done),
        .sum(sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle memories followed by a one-cycle multiplier
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_in_q         <= 32'd0;
            mem_wt_q         <= 32'd0;
            mul_result       <= 32'd0;
            mul_result_valid <= 1'b0;
        end else begin
            if (rd_en) begin
                mem_in_q <= in_mem[rd_addr];
                mem_wt_q <= wt_mem[rd_addr];
            end
            mul_result       <= mem_in_q * mem_wt_q;
            mul_result_valid <= mul_valid;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_sum(input int n, input logic [31:0] b);
        logic [31:0] s;
        s = b;
        for (int i = 0; i < n; i++) s = s + in_mem[i] * wt_mem[i];
        return s;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            in_mem[i] = $urandom;
            wt_mem[i] = $urandom;
        end
    endtask

    // Caller sits at a negedge; hold keeps start high, b2b expects one IDLE cycle first
    task automatic run_job(input int n, input logic [31:0] b, input bit hold,
                           input bit b2b, input bit mid);
        int neff, c, reads, addr_err, done_c, w;
        logic [31:0] exp_sum;
        neff    = (n > 1024) ? 1024 : n;
        exp_sum = model_sum(neff, b);
        vec_len = n[10:0];
        bias    = b;
        start   = 1'b1;
        w = 0;
        while (w < 5) begin
            @(negedge clk);
            w++;
            if (busy) break;
            chk("idle_sum_held", {32'd0, sum}, {32'd0, last_sum});
            chk("idle_done_low", {63'd0, done}, 64'd0);
        end
        chk("accept_wait", w, b2b ? 64'd2 : 64'd1);
        if (!hold) start = 1'b0;
        c = 1; reads = 0; addr_err = 0; done_c = 0;
        while (c <= neff + 10) begin
            if (rd_en) begin
                if (rd_addr != reads[9:0]) addr_err++;
                reads++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            if (mid && c == 2) begin
                start   = 1'b1;
                vec_len = 11'd5;
                bias    = 32'h1234;
            end else if (mid && c == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        chk("latency", done_c, (neff == 0) ? 64'd1 : 64'(neff + 3));
        chk("reads", reads, 64'(neff));
        chk("addr_seq", addr_err, 64'd0);
        chk("sum", {32'd0, sum}, {32'd0, exp_sum});
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        last_sum = exp_sum;
        if (!hold) begin
            @(negedge clk);
            chk("done_pulse", {63'd0, done}, 64'd0);
            chk("busy_idle", {63'd0, busy}, 64'd0);
            chk("sum_held", {32'd0, sum}, {32'd0, exp_sum});
        end
    endtask

    initial begin
        int dn;
        n_checks = 0;
        n_errors = 0;
        last_sum = 32'd0;
        reset    = 1'b0;
        start    = 1'b0;
        vec_len  = 11'd0;
        bias     = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            in_mem[i] = 32'd0;
            wt_mem[i] = 32'd0;
        end

        #1;
        chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_mul_valid", {63'd0, mul_valid}, 64'd0);
        chk("post_rst_addr", {54'd0, rd_addr}, 64'd0);

        // Directed: 4-element dot product
        in_mem[0] = 32'd1; in_mem[1] = 32'd2; in_mem[2] = 32'd3; in_mem[3] = 32'd4;
        wt_mem[0] = 32'd5; wt_mem[1] = 32'd6; wt_mem[2] = 32'd7; wt_mem[3] = 32'd8;
        run_job(4, 32'd10, 1'b0, 1'b0, 1'b0);
        chk("r4_sum_80", {32'd0, sum}, 64'd80);

        // Directed: empty vector returns the bias
        run_job(0, 32'h55, 1'b0, 1'b0, 1'b0);
        chk("r0_sum_bias", {32'd0, sum}, 64'h55);

        // Directed: accumulator wraps
        in_mem[0] = 32'd1; in_mem[1] = 32'd1; wt_mem[0] = 32'd1; wt_mem[1] = 32'd1;
        run_job(2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("wrap_sum_1", {32'd0, sum}, 64'd1);

        // Start pulsed during ISSUE must be ignored
        fill_random(3);
        run_job(3, $urandom, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(0, 20);
            fill_random(n);
            run_job(n, $urandom, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back jobs with start held high
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_random(n);
            run_job(n, $urandom, (k < 2), (k > 0), 1'b0);
        end

        // Oversized length clamps to 1024 elements
        fill_random(1024);
        run_job(2047, $urandom, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an 8-element job
        fill_random(8);
        vec_len = 11'd8;
        bias    = 32'd77;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_rd_en_before", {63'd0, rd_en}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("mid_rst_mul_valid", {63'd0, mul_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_addr", {54'd0, rd_addr}, 64'd0);
        chk("mid_rst_sum", {32'd0, sum}, 64'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += int'(done);
        end
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            dn += int'(done) + int'(busy);
        end
        chk("abandoned_no_done", dn, 64'd0);
        last_sum = 32'd0;
        in_mem[0] = 32'd3;
        wt_mem[0] = 32'd3;
        run_job(1, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_sum_9", {32'd0, sum}, 64'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
